// File: rtl/display_pkg.sv
// Shared definitions for the 7-segment display scan controller.
//   NUM_DIGITS   : digits on the display
//   AN_ALL_OFF   : anode pattern with every digit dark (anodes are active-low)
//   scan_state_e : scan FSM states
//   an_one_low   : anode pattern with only the indexed digit driven low
package display_pkg;

  localparam int NUM_DIGITS = 4;
  localparam logic [0:NUM_DIGITS-1] AN_ALL_OFF = 4'b1111;

  typedef enum logic [1:0] {
    ST_OFF   = 2'd0,
    ST_BLANK = 2'd1,
    ST_SHOW  = 2'd2
  } scan_state_e;

  function automatic logic [0:NUM_DIGITS-1] an_one_low(input logic [1:0] idx);
    logic [0:NUM_DIGITS-1] pat;
    pat      = AN_ALL_OFF;
    pat[idx] = 1'b0;
    return pat;
  endfunction

endpackage

// File: rtl/mod_n_counter.sv
// Modulo-N up counter with synchronous clear.
//   clk, rst : clock, asynchronous active-high reset
//   en       : advance by one this cycle
//   clr      : return to zero this cycle (overrides en)
//   count    : current value, 0 .. N-1
//   wrap     : high in the cycle whose edge takes count from N-1 back to 0
module mod_n_counter #(
  parameter  int N = 4,
  localparam int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         clr,
  output logic [W-1:0] count,
  output logic         wrap
);

  localparam logic [W-1:0] LAST = W'(N - 1);

  logic [W-1:0] count_d, count_q;

  assign wrap  = en && !clr && (count_q == LAST);
  assign count = count_q;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en) begin
      count_d = (count_q == LAST) ? '0 : count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/display_scan_ctrl.sv
// Time-multiplexed scan controller for a 4-digit common-anode 7-segment display.
//   clk, rst    : clock, asynchronous active-high reset
//   en          : scan enable; low blanks the display and parks the scan
//   digit_en    : per-digit enable, bit k = digit k
//   blink_mask  : per-digit blink select, bit k = digit k
//   sel         : digit index to the segment mux (sel[0] is the MSB)
//   an          : active-low anode enables, an[k] drives digit k
//   frame_tick  : one-cycle pulse when the scan wraps back to digit 0
//   blink_phase : 1 while blinking digits are dark
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_OFF   | scan disabled, all anodes off, sel and dwell count parked at 0
// ST_BLANK | first BLANK cycles of a dwell, all anodes off (anti-ghosting)
// ST_SHOW  | rest of the dwell, selected digit lit unless masked or blinked
module display_scan_ctrl
  import display_pkg::*;
#(
  parameter int DIV          = 50000,
  parameter int BLANK        = 16,
  parameter int BLINK_FRAMES = 125
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [0:NUM_DIGITS-1] digit_en,
  input  logic [0:NUM_DIGITS-1] blink_mask,
  output logic [0:1]            sel,
  output logic [0:NUM_DIGITS-1] an,
  output logic                  frame_tick,
  output logic                  blink_phase
);

  localparam int CW = $clog2(DIV);
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CW-1:0] BLANK_LAST = CW'((BLANK > 0) ? BLANK - 1 : 0);
  // With no blanking interval a dwell starts directly in SHOW.
  localparam scan_state_e DWELL_START = (BLANK > 0) ? ST_BLANK : ST_SHOW;

  scan_state_e           state_q, state_d;
  logic [1:0]            sel_q, sel_d;
  logic [0:NUM_DIGITS-1] an_q, an_d;
  logic                  frame_tick_q, frame_tick_d;
  logic                  blink_phase_q, blink_phase_d;

  logic [CW-1:0] cnt;
  logic          cnt_run;
  logic          dwell_wrap;
  logic          frame_evt;
  logic          frame_wrap;
  logic [FW-1:0] unused_frame_cnt;

  // The dwell counter idles at 0 in OFF so the first dwell after enable is full length.
  assign cnt_run   = en && (state_q != ST_OFF);
  assign frame_evt = dwell_wrap && (sel_q == 2'd3);

  mod_n_counter #(.N(DIV)) u_dwell_cnt (
    .clk   (clk),
    .rst   (rst),
    .en    (cnt_run),
    .clr   (!en),
    .count (cnt),
    .wrap  (dwell_wrap)
  );

  // Frame counter holds while disabled, so the blink rhythm resumes where it left off.
  mod_n_counter #(.N(BLINK_FRAMES)) u_frame_cnt (
    .clk   (clk),
    .rst   (rst),
    .en    (frame_evt),
    .clr   (1'b0),
    .count (unused_frame_cnt),
    .wrap  (frame_wrap)
  );

  always_comb begin
    state_d       = state_q;
    sel_d         = sel_q;
    frame_tick_d  = 1'b0;
    blink_phase_d = blink_phase_q ^ frame_wrap;

    if (!en) begin
      state_d = ST_OFF;
      sel_d   = 2'd0;
    end else begin
      unique case (state_q)
        ST_OFF: begin
          state_d = DWELL_START;
          sel_d   = 2'd0;
        end
        ST_BLANK: begin
          if (cnt == BLANK_LAST) state_d = ST_SHOW;
        end
        ST_SHOW: begin
          if (dwell_wrap) begin
            state_d      = DWELL_START;
            sel_d        = sel_q + 2'd1;
            frame_tick_d = (sel_q == 2'd3);
          end
        end
        default: state_d = ST_OFF;
      endcase
    end

    // Anodes are computed from next-cycle state so they line up with sel and blink_phase.
    an_d = AN_ALL_OFF;
    if (state_d == ST_SHOW && digit_en[sel_d] && !(blink_mask[sel_d] && blink_phase_d)) begin
      an_d = an_one_low(sel_d);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_OFF;
      sel_q         <= 2'd0;
      an_q          <= AN_ALL_OFF;
      frame_tick_q  <= 1'b0;
      blink_phase_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      sel_q         <= sel_d;
      an_q          <= an_d;
      frame_tick_q  <= frame_tick_d;
      blink_phase_q <= blink_phase_d;
    end
  end

  assign sel         = sel_q;
  assign an          = an_q;
  assign frame_tick  = frame_tick_q;
  assign blink_phase = blink_phase_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
module tb_display_scan_ctrl;

  logic       clk;
  logic       rst;
  logic       en;
  logic [0:3] digit_en;
  logic [0:3] blink_mask;

  logic [0:1] sel_a, sel_b;
  logic [0:3] an_a, an_b;
  logic       ft_a, ft_b, bp_a, bp_b;

  int vectors    = 0;
  int miscompares = 0;

  // Instance A: DIV=8, BLANK=2, BLINK_FRAMES=2.  Instance B: DIV=4, BLANK=0, BLINK_FRAMES=1.
  display_scan_ctrl #(.DIV(8), .BLANK(2), .BLINK_FRAMES(2)) u_dut_a (
    .clk(clk), .rst(rst), .en(en), .digit_en(digit_en), .blink_mask(blink_mask),
    .sel(sel_a), .an(an_a), .frame_tick(ft_a), .blink_phase(bp_a)
  );

  display_scan_ctrl #(.DIV(4), .BLANK(0), .BLINK_FRAMES(1)) u_dut_b (
    .clk(clk), .rst(rst), .en(en), .digit_en(digit_en), .blink_mask(blink_mask),
    .sel(sel_b), .an(an_b), .frame_tick(ft_b), .blink_phase(bp_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int p_div(input int i);
    return (i == 0) ? 8 : 4;
  endfunction
  function automatic int p_blank(input int i);
    return (i == 0) ? 2 : 0;
  endfunction
  function automatic int p_bf(input int i);
    return (i == 0) ? 2 : 1;
  endfunction

  // Reference model: position in the scan is simply elapsed cycles since enable.
  bit         m_on     [2];
  int         m_t      [2];
  int         m_frames [2];
  logic [1:0] exp_sel  [2];
  logic [0:3] exp_an   [2];
  logic       exp_ft   [2];
  logic       exp_bp   [2];
  int         md, mpos;

  always @(posedge clk or posedge rst) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        m_on[i] = 0; m_t[i] = 0; m_frames[i] = 0;
        exp_sel[i] = 2'd0; exp_an[i] = 4'b1111; exp_ft[i] = 1'b0; exp_bp[i] = 1'b0;
      end else if (!en) begin
        m_on[i] = 0;
        exp_sel[i] = 2'd0; exp_an[i] = 4'b1111; exp_ft[i] = 1'b0;
      end else begin
        if (m_on[i]) m_t[i] = m_t[i] + 1;
        else begin m_on[i] = 1; m_t[i] = 0; end
        md   = (m_t[i] / p_div(i)) % 4;
        mpos = m_t[i] % p_div(i);
        exp_ft[i] = (m_t[i] > 0) && (m_t[i] % (4 * p_div(i)) == 0);
        if (exp_ft[i]) m_frames[i] = m_frames[i] + 1;
        exp_bp[i]  = ((m_frames[i] / p_bf(i)) % 2) == 1;
        exp_sel[i] = 2'(md);
        exp_an[i]  = 4'b1111;
        if (mpos >= p_blank(i) && digit_en[md] && !(blink_mask[md] && exp_bp[i]))
          exp_an[i][md] = 1'b0;
      end
    end
  end

  task automatic check(input string nm, input logic [3:0] act, input logic [3:0] exp_v);
    vectors++;
    if (act !== exp_v) begin
      miscompares++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp_v, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      check("sel_a", {2'b00, sel_a}, {2'b00, exp_sel[0]});
      check("an_a",  an_a,           exp_an[0]);
      check("ft_a",  {3'b000, ft_a}, {3'b000, exp_ft[0]});
      check("bp_a",  {3'b000, bp_a}, {3'b000, exp_bp[0]});
      check("sel_b", {2'b00, sel_b}, {2'b00, exp_sel[1]});
      check("an_b",  an_b,           exp_an[1]);
      check("ft_b",  {3'b000, ft_b}, {3'b000, exp_ft[1]});
      check("bp_b",  {3'b000, bp_b}, {3'b000, exp_bp[1]});
    end
  end

  task automatic check_reset_vals(input string tag);
    check({tag, "_sel_a"}, {2'b00, sel_a}, 4'd0);
    check({tag, "_an_a"},  an_a,           4'b1111);
    check({tag, "_ft_a"},  {3'b000, ft_a}, 4'd0);
    check({tag, "_bp_a"},  {3'b000, bp_a}, 4'd0);
    check({tag, "_sel_b"}, {2'b00, sel_b}, 4'd0);
    check({tag, "_an_b"},  an_b,           4'b1111);
    check({tag, "_ft_b"},  {3'b000, ft_b}, 4'd0);
    check({tag, "_bp_b"},  {3'b000, bp_b}, 4'd0);
  endtask

  task automatic fail_timeout(input string nm);
    vectors++;
    miscompares++;
    $display("FAIL %s: wait expired, got timeout expected event", nm);
  endtask

  logic held_bp;
  bit   found;

  initial begin
    rst = 1'b1; en = 1'b1; digit_en = 4'b1111; blink_mask = 4'b0000;
    repeat (3) @(negedge clk);
    check_reset_vals("rst_hold");
    rst = 1'b0;

    // Basic scan with literal pins on known cycles.
    for (int k = 0; k < 80; k++) begin
      @(negedge clk);
      case (k)
        0:  begin check("pin_b_an0", an_b, 4'b0111); check("pin_b_sel0", {2'b00, sel_b}, 4'd0); end
        1:  begin check("pin_a_blank", an_a, 4'b1111); check("pin_a_sel0", {2'b00, sel_a}, 4'd0); end
        2:  begin check("pin_a_lit0", an_a, 4'b0111); check("pin_model_a_lit0", exp_an[0], 4'b0111); end
        4:  begin check("pin_b_an1", an_b, 4'b1011); check("pin_b_sel1", {2'b00, sel_b}, 4'd1); end
        7:  check("pin_a_lit0_end", an_a, 4'b0111);
        8:  begin check("pin_a_sel1", {2'b00, sel_a}, 4'd1); check("pin_a_blank1", an_a, 4'b1111); end
        10: check("pin_a_lit1", an_a, 4'b1011);
        15: check("pin_b_bp_pre", {3'b000, bp_b}, 4'd0);
        16: begin check("pin_b_ft", {3'b000, ft_b}, 4'd1); check("pin_b_bp", {3'b000, bp_b}, 4'd1); end
        31: begin check("pin_a_sel3", {2'b00, sel_a}, 4'd3); check("pin_a_lit3", an_a, 4'b1110); end
        32: begin
          check("pin_a_ft", {3'b000, ft_a}, 4'd1);
          check("pin_a_ft_sel", {2'b00, sel_a}, 4'd0);
          check("pin_model_a_ft", {3'b000, exp_ft[0]}, 4'd1);
        end
        33: check("pin_a_ft_off", {3'b000, ft_a}, 4'd0);
        63: check("pin_a_bp_pre", {3'b000, bp_a}, 4'd0);
        64: begin check("pin_a_bp", {3'b000, bp_a}, 4'd1); check("pin_model_a_bp", {3'b000, exp_bp[0]}, 4'd1); end
        default: ;
      endcase
    end

    digit_en = 4'b0110;
    repeat (40) @(negedge clk);

    digit_en = 4'b1111; blink_mask = 4'b0001;
    repeat (200) @(negedge clk);

    // Drop enable while digit 2 of instance A is lit.
    blink_mask = 4'b0000;
    found = 0;
    for (int w = 0; w < 80 && !found; w++) begin
      @(negedge clk);
      if (exp_sel[0] == 2'd2 && exp_an[0] != 4'b1111) found = 1;
    end
    if (!found) fail_timeout("dis_wait");
    held_bp = exp_bp[0];
    en = 1'b0;
    @(negedge clk);
    check("dis_an_a",  an_a,           4'b1111);
    check("dis_sel_a", {2'b00, sel_a}, 4'd0);
    check("dis_ft_a",  {3'b000, ft_a}, 4'd0);
    check("dis_bp_a",  {3'b000, bp_a}, {3'b000, held_bp});
    repeat (3) @(negedge clk);
    check("dis_bp_a_hold", {3'b000, bp_a}, {3'b000, held_bp});
    en = 1'b1;
    @(negedge clk);
    check("re_an_a0",  an_a,           4'b1111);
    check("re_sel_a0", {2'b00, sel_a}, 4'd0);
    @(negedge clk);
    check("re_an_a1",  an_a,           4'b1111);
    @(negedge clk);
    check("re_an_a2",  an_a,           4'b0111);

    // Randomized enable and mask traffic.
    for (int r = 0; r < 4000; r++) begin
      @(negedge clk);
      if (en) begin
        if ($urandom_range(0, 199) == 0) en = 1'b0;
      end else if ($urandom_range(0, 4) == 0) begin
        en = 1'b1;
      end
      if ($urandom_range(0, 63) == 0) digit_en   = 4'($urandom);
      if ($urandom_range(0, 63) == 0) blink_mask = 4'($urandom);
    end

    // Asynchronous reset in the middle of a lit dwell.
    en = 1'b1; digit_en = 4'b1111; blink_mask = 4'b0000;
    found = 0;
    for (int w = 0; w < 200 && !found; w++) begin
      @(negedge clk);
      if (exp_sel[0] != 2'd0 && exp_an[0] != 4'b1111) found = 1;
    end
    if (!found) fail_timeout("async_wait");
    @(posedge clk);
    #2 rst = 1'b1;
    #1 check_reset_vals("rst_async");
    repeat (2) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
